// File: rtl/j_u2pscl_mc.sv
// Multi-channel UART baud prescaler: per-channel reload down-counter
// producing a x16 baud enable and a bit-rate enable every 16th pulse.
module j_u2pscl_mc #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 2,
   parameter int SELW     = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [WIDTH-1:0]    din,
   input  logic [SELW-1:0]     sel,
   input  logic                psclw,
   input  logic                psclr,
   output logic [WIDTH-1:0]    dr_out,
   output logic                dr_oe,
   input  logic [CHANNELS-1:0] chen,
   output logic [CHANNELS-1:0] bx16,
   output logic [CHANNELS-1:0] bx1
);

   logic [WIDTH-1:0]    pscl_q [CHANNELS];
   logic [WIDTH-1:0]    pscl_d [CHANNELS];
   logic [WIDTH-1:0]    cnt_q  [CHANNELS];
   logic [WIDTH-1:0]    cnt_d  [CHANNELS];
   logic [3:0]          sub_q  [CHANNELS];
   logic [3:0]          sub_d  [CHANNELS];
   logic [CHANNELS-1:0] bx16_q, bx16_d;
   logic [CHANNELS-1:0] bx1_q, bx1_d;
   logic [WIDTH-1:0]    dr_out_q, dr_out_d;
   logic                dr_oe_q, dr_oe_d;
   logic [31:0]         sel_ext;

   assign sel_ext = 32'(sel);

   always_comb begin
      pscl_d   = pscl_q;
      cnt_d    = cnt_q;
      sub_d    = sub_q;
      bx16_d   = '0;
      bx1_d    = '0;
      dr_oe_d  = psclr;
      dr_out_d = '0;

      for (int c = 0; c < CHANNELS; c++) begin
         // Read returns pre-edge value; out-of-range select reads zero
         if (psclr && sel_ext == 32'(c)) begin
            dr_out_d = pscl_q[c];
         end

         if (psclw && sel_ext == 32'(c)) begin
            pscl_d[c] = din;
            cnt_d[c]  = din;
            sub_d[c]  = 4'd0;
         end else if (chen[c]) begin
            if (cnt_q[c] == '0) begin
               cnt_d[c]  = pscl_q[c];
               sub_d[c]  = sub_q[c] + 4'd1;
               bx16_d[c] = 1'b1;
               bx1_d[c]  = (sub_q[c] == 4'hf);
            end else begin
               cnt_d[c] = cnt_q[c] - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pscl_q   <= '{default: '0};
         cnt_q    <= '{default: '0};
         sub_q    <= '{default: '0};
         bx16_q   <= '0;
         bx1_q    <= '0;
         dr_out_q <= '0;
         dr_oe_q  <= 1'b0;
      end else begin
         pscl_q   <= pscl_d;
         cnt_q    <= cnt_d;
         sub_q    <= sub_d;
         bx16_q   <= bx16_d;
         bx1_q    <= bx1_d;
         dr_out_q <= dr_out_d;
         dr_oe_q  <= dr_oe_d;
      end
   end

   assign bx16   = bx16_q;
   assign bx1    = bx1_q;
   assign dr_out = dr_out_q;
   assign dr_oe  = dr_oe_q;

endmodule
